// File: rtl/motor_step_scheduler.sv
// Round-robin step/direction generator for four position-controlled motors.
// Optional build macro STEP_LIMIT_EN clamps every target to +/-POS_LIMIT.
module motor_step_scheduler #(
  parameter int STEP_DIV  = 50000,
  parameter int PULSE_W   = 100,
  parameter int POS_LIMIT = 2000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [31:0] target1,
  input  logic signed [31:0] target2,
  input  logic signed [31:0] target3,
  input  logic signed [31:0] target4,
  output logic [3:0]         step,
  output logic [3:0]         dir,
  output logic signed [31:0] cur_pos1,
  output logic signed [31:0] cur_pos2,
  output logic signed [31:0] cur_pos3,
  output logic signed [31:0] cur_pos4,
  output logic [3:0]         at_target,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PW_W  = $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {WAIT, SETUP, PULSE} state_t;

  function automatic logic signed [31:0] clamp_target(input logic signed [31:0] t);
`ifdef STEP_LIMIT_EN
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = 32'(POS_LIMIT);
    lo = -hi;
    if (t > hi) return hi;
    if (t < lo) return lo;
    return t;
`else
    return t;
`endif
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [PW_W-1:0]    pcnt;
  logic [1:0]         sel;
  logic [1:0]         last_sel;
  logic               dir_up;
  logic               busy_d;
  logic signed [31:0] cur [4];
  logic signed [31:0] tgt [4];
  logic               tick;
  logic [3:0]         pending;
  logic [1:0]         nxt_sel;
  logic               nxt_up;

  assign tgt[0] = clamp_target(target1);
  assign tgt[1] = clamp_target(target2);
  assign tgt[2] = clamp_target(target3);
  assign tgt[3] = clamp_target(target4);

  assign cur_pos1 = cur[0];
  assign cur_pos2 = cur[1];
  assign cur_pos3 = cur[2];
  assign cur_pos4 = cur[3];

  assign tick = (count == CNT_W'(STEP_DIV - 1));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      at_target[i] = (cur[i] == tgt[i]);
    end
    pending = ~at_target;
  end

  // First pending motor after the one served last, wrapping 3 -> 0.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    found   = 1'b0;
    nxt_sel = last_sel;
    cand    = last_sel;
    for (int k = 1; k <= 4; k++) begin
      cand = last_sel + 2'(k);
      if (!found && pending[cand]) begin
        nxt_sel = cand;
        found   = 1'b1;
      end
    end
    nxt_up = (tgt[nxt_sel] > cur[nxt_sel]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT;
      count    <= '0;
      pcnt     <= '0;
      sel      <= '0;
      last_sel <= 2'd3;
      dir_up   <= 1'b0;
      step     <= '0;
      dir      <= '0;
      busy     <= 1'b0;
      busy_d   <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur[i] <= '0;
      end
    end else begin
      count  <= tick ? '0 : count + 1'b1;
      busy   <= (state != WAIT) || (enable && (pending != 4'b0000));
      busy_d <= busy;
      done   <= busy_d && !busy;
      case (state)
        WAIT: begin
          // Direction is driven here so it leads the step edge by one cycle.
          if (tick && enable && (pending != 4'b0000)) begin
            sel          <= nxt_sel;
            dir[nxt_sel] <= nxt_up;
            dir_up       <= nxt_up;
            state        <= SETUP;
          end
        end
        SETUP: begin
          step[sel] <= 1'b1;
          pcnt      <= '0;
          state     <= PULSE;
        end
        PULSE: begin
          if (pcnt == PW_W'(PULSE_W - 1)) begin
            step     <= '0;
            cur[sel] <= dir_up ? cur[sel] + 32'sd1 : cur[sel] - 32'sd1;
            last_sel <= sel;
            state    <= WAIT;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_step_scheduler.sv
// Slot-level reference model bench for motor_step_scheduler (STEP_DIV=10, PULSE_W=3).
module tb_motor_step_scheduler;

  localparam int STEP_DIV  = 10;
  localparam int PULSE_W   = 3;
  localparam int POS_LIMIT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic signed [31:0] tg1 = 0, tg2 = 0, tg3 = 0, tg4 = 0;
  logic [3:0] step, dir, at_target;
  logic signed [31:0] cp1, cp2, cp3, cp4;
  logic busy, done;

  motor_step_scheduler #(.STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W), .POS_LIMIT(POS_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .target1(tg1), .target2(tg2), .target3(tg3), .target4(tg4),
    .step(step), .dir(dir),
    .cur_pos1(cp1), .cur_pos2(cp2), .cur_pos3(cp3), .cur_pos4(cp4),
    .at_target(at_target), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  logic [3:0] prev_step = 4'b0;

  always @(negedge clk) begin
    rise_cnt  <= rise_cnt + $countones(step & ~prev_step);
    prev_step <= step;
    done_cnt  <= done_cnt + (done ? 1 : 0);
  end

  // Reference model: one entry per motor, advanced once per step slot.
  int         mcur [4];
  int         mlast;
  logic [3:0] mdir;
  int         drv_t [4];
  logic       drv_en;
  bit         mid_chg;
  logic       mid_en;
  int         mid_t0;

  function automatic int clampv(input int v);
`ifdef STEP_LIMIT_EN
    if (v > POS_LIMIT) return POS_LIMIT;
    if (v < -POS_LIMIT) return -POS_LIMIT;
`endif
    return v;
  endfunction

  function automatic logic [3:0] exp_at();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mcur[i] == clampv(drv_t[i]));
    return r;
  endfunction

  function automatic logic signed [31:0] get_cp(input int i);
    case (i)
      0: return cp1;
      1: return cp2;
      2: return cp3;
      default: return cp4;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_inputs();
    enable = drv_en;
    tg1 = drv_t[0];
    tg2 = drv_t[1];
    tg3 = drv_t[2];
    tg4 = drv_t[3];
  endtask

  // Entered in the tick cycle; leaves in the next tick cycle.
  task automatic do_slot();
    int sel;
    int idx;
    logic up;
    logic [3:0] exp_step;
    apply_inputs();
    sel = -1;
    up = 1'b0;
    if (drv_en) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (mlast + k) % 4;
        if (sel < 0 && mcur[idx] != clampv(drv_t[idx])) sel = idx;
      end
    end
    exp_step = 4'b0;
    if (sel >= 0) begin
      up = (clampv(drv_t[sel]) > mcur[sel]);
      mdir[sel] = up;
      exp_step = 4'(1 << sel);
    end
    cyc();
    n_vec++;
    if (dir !== mdir) begin
      n_err++; $display("FAIL slot_dir: got %b want %b", dir, mdir);
    end
    n_vec++;
    if (step !== 4'b0) begin
      n_err++; $display("FAIL slot_setup_step: got %b want 0000", step);
    end
    for (int p = 0; p < PULSE_W; p++) begin
      cyc();
      n_vec++;
      if (step !== exp_step) begin
        n_err++; $display("FAIL slot_pulse%0d: got %b want %b", p, step, exp_step);
      end
      if (p == 0 && mid_chg) begin
        drv_en = mid_en;
        drv_t[0] = mid_t0;
        apply_inputs();
      end
    end
    cyc();
    if (sel >= 0) begin
      mcur[sel] = mcur[sel] + (up ? 1 : -1);
      mlast = sel;
    end
    n_vec++;
    if (step !== 4'b0) begin
      n_err++; $display("FAIL slot_step_low: got %b want 0000", step);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (get_cp(i) !== 32'(mcur[i])) begin
        n_err++; $display("FAIL slot_cur_pos%0d: got %0d want %0d", i + 1, get_cp(i), mcur[i]);
      end
    end
    n_vec++;
    if (at_target !== exp_at()) begin
      n_err++; $display("FAIL slot_at_target: got %b want %b", at_target, exp_at());
    end
    mid_chg = 1'b0;
    repeat (STEP_DIV - PULSE_W - 2) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv_t[i] = 0;
      mcur[i] = 0;
    end
    mlast = 3;
    mdir = 4'b0;
    mid_chg = 1'b0;
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (STEP_DIV - 1) cyc();
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    drv_en = 1'b1;
    for (int i = 0; i < 4; i++) drv_t[i] = 5;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (step !== 4'b0) begin n_err++; $display("FAIL reset_step: got %b want 0000", step); end
    n_vec++;
    if (dir !== 4'b0) begin n_err++; $display("FAIL reset_dir: got %b want 0000", dir); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (get_cp(i) !== 32'sd0) begin
        n_err++; $display("FAIL reset_cur_pos%0d: got %0d want 0", i + 1, get_cp(i));
      end
    end
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
    end
    n_vec++;
    if (at_target !== 4'b0) begin n_err++; $display("FAIL reset_at_target: got %b want 0000", at_target); end
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      #1;
      if (step !== 4'b0) break;
    end
    n_vec++;
    if (n != 11) begin n_err++; $display("FAIL reset_first_step_latency: got %0d want 11", n); end
    n_vec++;
    if (step !== 4'b0001) begin n_err++; $display("FAIL reset_first_step_motor: got %b want 0001", step); end
    do_reset();
  endtask

  task automatic test_single();
    int r0, d0;
    do_reset();
    r0 = rise_cnt; d0 = done_cnt;
    drv_t[0] = 3; drv_en = 1'b1;
    repeat (4) do_slot();
    n_vec++;
    if (cp1 !== 32'sd3) begin n_err++; $display("FAIL single_cur_pos1: got %0d want 3", cp1); end
    n_vec++;
    if (at_target !== 4'b1111) begin n_err++; $display("FAIL single_at_target: got %b want 1111", at_target); end
    n_vec++;
    if (dir[0] !== 1'b1) begin n_err++; $display("FAIL single_dir0: got %b want 1", dir[0]); end
    n_vec++;
    if (rise_cnt - r0 != 3) begin n_err++; $display("FAIL single_pulses: got %0d want 3", rise_cnt - r0); end
    n_vec++;
    if (done_cnt - d0 != 1) begin n_err++; $display("FAIL single_done: got %0d want 1", done_cnt - d0); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int r0;
    do_reset();
    r0 = rise_cnt;
    drv_t[0] = 2; drv_t[1] = -1; drv_en = 1'b1;
    repeat (4) do_slot();
    n_vec++;
    if (cp1 !== 32'sd2 || cp2 !== -32'sd1) begin
      n_err++; $display("FAIL rr_positions: got %0d,%0d want 2,-1", cp1, cp2);
    end
    n_vec++;
    if (dir[1] !== 1'b0) begin n_err++; $display("FAIL rr_dir1: got %b want 0", dir[1]); end
    n_vec++;
    if (rise_cnt - r0 != 3) begin n_err++; $display("FAIL rr_pulses: got %0d want 3", rise_cnt - r0); end
  endtask

  task automatic test_retarget();
    do_reset();
    drv_t[0] = 1; drv_en = 1'b1;
    mid_chg = 1'b1; mid_en = 1'b1; mid_t0 = -1;
    do_slot();
    n_vec++;
    if (cp1 !== 32'sd1) begin n_err++; $display("FAIL retarget_inflight: got %0d want 1", cp1); end
    repeat (3) do_slot();
    n_vec++;
    if (cp1 !== -32'sd1) begin n_err++; $display("FAIL retarget_final: got %0d want -1", cp1); end
    n_vec++;
    if (dir[0] !== 1'b0) begin n_err++; $display("FAIL retarget_dir0: got %b want 0", dir[0]); end
  endtask

  task automatic test_enable_drop();
    int r0;
    do_reset();
    r0 = rise_cnt;
    drv_t[0] = 3; drv_en = 1'b1;
    mid_chg = 1'b1; mid_en = 1'b0; mid_t0 = 3;
    do_slot();
    repeat (2) do_slot();
    n_vec++;
    if (cp1 !== 32'sd1) begin n_err++; $display("FAIL endrop_cur_pos1: got %0d want 1", cp1); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL endrop_busy: got %b want 0", busy); end
    n_vec++;
    if (rise_cnt - r0 != 1) begin n_err++; $display("FAIL endrop_pulses: got %0d want 1", rise_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drv_t[0] = 2; drv_en = 1'b1;
    do_slot();
    apply_inputs();
    repeat (3) cyc();
    n_vec++;
    if (step !== 4'b0001) begin n_err++; $display("FAIL rstmid_pulse: got %b want 0001", step); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (step !== 4'b0) begin n_err++; $display("FAIL rstmid_step: got %b want 0000", step); end
    n_vec++;
    if (cp1 !== 32'sd0) begin n_err++; $display("FAIL rstmid_cur_pos1: got %0d want 0", cp1); end
    n_vec++;
    if (dir !== 4'b0) begin n_err++; $display("FAIL rstmid_dir: got %b want 0000", dir); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 40; s++) begin
      if (s == 0 || $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++) drv_t[i] = int'($urandom_range(0, 6)) - 3;
      end
      drv_en = ($urandom_range(0, 4) != 0);
      do_slot();
    end
  endtask

  task automatic test_limit();
    int d0;
    do_reset();
    d0 = done_cnt;
    drv_t[0] = 100; drv_en = 1'b1;
    repeat (8) do_slot();
`ifdef STEP_LIMIT_EN
    n_vec++;
    if (cp1 !== 32'sd5) begin n_err++; $display("FAIL limit_cur_pos1: got %0d want 5", cp1); end
    n_vec++;
    if (at_target[0] !== 1'b1) begin n_err++; $display("FAIL limit_at_target0: got %b want 1", at_target[0]); end
    n_vec++;
    if (done_cnt - d0 != 1) begin n_err++; $display("FAIL limit_done: got %0d want 1", done_cnt - d0); end
`else
    n_vec++;
    if (cp1 !== 32'sd8) begin n_err++; $display("FAIL limit_cur_pos1: got %0d want 8", cp1); end
    n_vec++;
    if (at_target[0] !== 1'b0) begin n_err++; $display("FAIL limit_at_target0: got %b want 0", at_target[0]); end
    n_vec++;
    if (done_cnt - d0 != 0) begin n_err++; $display("FAIL limit_done: got %0d want 0", done_cnt - d0); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mlast = 3;
    mdir = 4'b0;
    drv_en = 1'b0;
    mid_chg = 1'b0;
    mid_en = 1'b0;
    mid_t0 = 0;
    for (int i = 0; i < 4; i++) begin
      mcur[i] = 0;
      drv_t[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_retarget();
    test_enable_drop();
    test_reset_mid();
    test_random();
    test_limit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motor_step_scheduler.md
# motor_step_scheduler

Time-multiplexed step/direction generator for the four wheel motor-position registers in the memory-mapped RAM block. It takes the four 32-bit signed target positions published by the RAM (addresses 10–13) and keeps an internal current position per motor. It steps each lagging motor one unit at a time toward its target, sharing a single step-rate budget among the motors in round-robin order. It sits between the RAM's motor-position outputs and the motor driver pins.

## Interface
Parameters:
- STEP_DIV, 50000: clock cycles per step slot. Required: STEP_DIV > PULSE_W + 2. Not checked in hardware.
- PULSE_W, 100: step pulse high width, in clock cycles (≥1).
- POS_LIMIT, 2000: soft position limit magnitude. Used only with STEP_LIMIT_EN.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  permits new steps to start.
- target1..target4  in  32 each  signed target positions (from motorposition1..4).
- step  out  4  step pulse, one bit per motor.
- dir  out  4  direction per motor; 1 = increasing position.
- cur_pos1..cur_pos4  out  32 each  signed current positions.
- at_target  out  4  bit i = (cur_pos == target) for motor i. Combinational from registered cur_pos and live target.
- busy  out  1  a step is in flight, or enable=1 and any at_target bit is 0.
- done  out  1  one-cycle pulse on busy 1→0.

## Operation
- Free-running tick counter: 0..STEP_DIV-1, wraps. tick = (count == STEP_DIV-1). Counts from reset regardless of enable.
- FSM states and transitions:
  - WAIT → SETUP: on tick with enable=1 and at least one motor pending (cur ≠ target).
    - The selected motor is the first pending index after last_sel, wrapping 3→0.
    - last_sel resets to 3, so motor 0 is served first.
  - SETUP (1 cycle): latch sel; set dir[sel] = (target_sel > cur_sel), signed compare; latch step direction → PULSE.
  - PULSE (PULSE_W cycles): step[sel] = 1.
    - On the last cycle, cur_pos[sel] ± 1 per latched direction; last_sel = sel → WAIT.
- Targets are sampled only at tick and in SETUP.
  - A target change during PULSE does not abort or reverse the in-flight step.
  - The change takes effect at the next tick.
- enable deassert: the in-flight pulse completes; no new selection.
- At most one motor steps per slot. Aggregate rate is clk/STEP_DIV, shared among the motors.
- dir bits of unselected motors hold their last value.
- Arithmetic: 32-bit two's complement, signed compare. cur_pos never wraps, because it only moves toward a representable target.
- No-op: tick with no pending motor stays in WAIT; last_sel is unchanged.

## Timing
- Reset values: step=0, dir=0, cur_pos1..4=0, busy=0, done=0, state WAIT, count=0, last_sel=3. at_target follows targets.
- Tick at cycle T:
  - SETUP at T+1; dir valid from T+1.
  - step high for cycles T+2 .. T+1+PULSE_W.
  - cur_pos updated and visible from T+2+PULSE_W.
  - Dir-to-step setup is 1 cycle.
- done: asserted the cycle after busy falls, for exactly 1 cycle.
- Reset mid-operation: all outputs clear asynchronously, including cur_pos. A partial pulse is truncated.

## Configuration
- STEP_LIMIT_EN defined:
  - Each target is clamped to [-POS_LIMIT, +POS_LIMIT] before comparison.
  - Motors therefore stop at the limit, and at_target compares against the clamped value.
- STEP_LIMIT_EN undefined: targets are used unclamped. POS_LIMIT is ignored.

## Test plan
All scenarios use STEP_DIV=10, PULSE_W=3.

- Reset: hold rst_n=0 with targets=5 → step=0, dir=0, cur_pos=0, busy=0. Release rst_n → first step rising edge 11 cycles after release (count reaches 9, then SETUP, then PULSE).
- Single motor: target1=3, others 0, enable=1 → exactly 3 pulses on step[0], each 3 cycles wide, 10 cycles apart; dir[0]=1; cur_pos1=3; at_target=4'b1111; one done pulse.
- Round-robin: target1=2, target2=-1 → slot order motor1, motor2, motor1; dir[1]=0; final cur_pos1=2, cur_pos2=-1; three total pulses.
- Mid-pulse retarget: target1=1; during PULSE, set target1=-1 → pulse completes; cur_pos1=1; next two slots step down; final cur_pos1=-1.
- Enable/reset mid-pulse:
  - Drop enable during PULSE → pulse completes and no further steps; busy=0.
  - Assert rst_n=0 during PULSE → step falls in the same cycle and cur_pos1=0.
- STEP_LIMIT_EN, POS_LIMIT=5, target1=100 → 5 steps; cur_pos1=5; at_target[0]=1; done pulses.
